// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package bin2bcd_pkg;

  // Converter control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Number of decimal digits needed to represent 2**bin_w - 1.
  function automatic int min_digits(input int bin_w);
    longint unsigned v;
    int              n;
    v = (64'd1 << bin_w) - 64'd1;
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bin2bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
// Latency: combinational. Backpressure: n/a.
// Ports: digit_i - accumulator digit before the shift; digit_o - corrected digit.
module bin2bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Latency: out_valid rises BIN_W edges after the accepting edge; BIN_W+2 cycle request spacing.
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
// Ports: clk/reset_n (async active-low); in_valid/in_ready/bin request side;
//        out_valid/out_ready/bcd/overflow result side (digit 0 in bcd[3:0]).
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int CNT_W      = $clog2(BIN_W + 1);
  localparam int ACC_W      = 4 * DIGITS;
  localparam int MIN_DIGITS = min_digits(BIN_W);
  // When enough digits are configured no 1 can ever leave the top digit,
  // so the overflow path is tied off at elaboration.
  localparam bit CAN_OVF    = (DIGITS < MIN_DIGITS);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_adj;
  logic [BIN_W-1:0]   opnd_q, opnd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bin2bcd_digit_adj u_adj (
      .digit_i (acc_q[4*g +: 4]),
      .digit_o (acc_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          opnd_d  = bin;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Shift {corrected accumulator, operand} left by one; the bit that
        // falls off the top digit is lost and marks the result as truncated.
        acc_d  = {acc_adj[ACC_W-2:0], opnd_q[BIN_W-1]};
        opnd_d = {opnd_q[BIN_W-2:0], 1'b0};
        ovf_d  = ovf_q | (acc_adj[ACC_W-1] & CAN_OVF);
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bcd      = acc_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: three instances (8/3, 16/5, 8/2 digits).
// Stimulus pushes hand-computed results; a negedge monitor pops and compares.
module tb_bin2bcd_seq;

  typedef struct {
    logic [19:0] bcd;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] bin_s;
  logic        in_vld  [3];
  logic        in_rdy  [3];
  logic        out_vld [3];
  logic        out_rdy [3];
  logic        ovf     [3];
  logic [11:0] bcd0;
  logic [19:0] bcd1;
  logic [7:0]  bcd2;
  logic [19:0] bcd_w   [3];

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int          last_acc [3] = '{0, 0, 0};
  int          prev_acc [3] = '{0, 0, 0};
  int          lat_exp  [3] = '{8, 16, 8};
  logic [19:0] held     [3];
  logic        prev_v   [3];
  exp_t        sb[$];

  assign bcd_w[0] = {8'd0, bcd0};
  assign bcd_w[1] = bcd1;
  assign bcd_w[2] = {12'd0, bcd2};

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_vld[0]), .in_ready(in_rdy[0]),
    .bin(bin_s[7:0]), .out_valid(out_vld[0]), .out_ready(out_rdy[0]),
    .bcd(bcd0), .overflow(ovf[0]));

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_vld[1]), .in_ready(in_rdy[1]),
    .bin(bin_s), .out_valid(out_vld[1]), .out_ready(out_rdy[1]),
    .bcd(bcd1), .overflow(ovf[1]));

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_vld[2]), .in_ready(in_rdy[2]),
    .bin(bin_s[7:0]), .out_valid(out_vld[2]), .out_ready(out_rdy[2]),
    .bcd(bcd2), .overflow(ovf[2]));

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks = checks + 1;
    errors = errors + 1;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Monitor: records accept edges, checks latency and hold stability,
  // and pops the scoreboard on every result handshake.
  initial begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      prev_v[k] = 1'b0;
      held[k]   = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!reset_n) begin
          prev_v[k] = 1'b0;
        end else begin
          if (in_vld[k] && in_rdy[k]) begin
            prev_acc[k] = last_acc[k];
            last_acc[k] = cyc + 1;
          end
          if (out_vld[k] && !prev_v[k]) begin
            check("latency", cyc - last_acc[k], lat_exp[k]);
            held[k] = bcd_w[k];
          end
          if (out_vld[k] && !out_rdy[k]) begin
            check("hold_bcd", bcd_w[k], held[k]);
            check("hold_in_ready", in_rdy[k], 1'b0);
          end
          if (out_vld[k] && out_rdy[k]) begin
            if (sb.size() == 0) begin
              timeout("unexpected_output");
            end else begin
              e = sb.pop_front();
              check("bcd", bcd_w[k], e.bcd);
              check("overflow", ovf[k], e.ovf);
            end
          end
          prev_v[k] = out_vld[k];
        end
      end
    end
  end

  task automatic send(input int k, input logic [15:0] b, input logic [19:0] eb,
                      input logic eo, input bit push);
    exp_t e;
    bit   ok;
    @(posedge clk);
    #1;
    if (push) begin
      e.bcd = eb;
      e.ovf = eo;
      sb.push_back(e);
    end
    bin_s     = b;
    in_vld[k] = 1'b1;
    ok        = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_rdy[k]) ok = 1'b1;
    end
    if (!ok) timeout("accept");
    @(posedge clk);
    #1;
    in_vld[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (out_vld[k]) ok = 1'b1;
    end
    if (!ok) timeout("out_valid");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n = n + 1;
    end
    if (sb.size() != 0) begin
      timeout("drain");
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rel;
    reset_n = 1'b0;
    bin_s   = '0;
    for (int k = 0; k < 3; k++) begin
      in_vld[k]  = 1'b0;
      out_rdy[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_in_ready", in_rdy[k], 1'b1);
      check("rst_out_valid", out_vld[k], 1'b0);
      check("rst_bcd", bcd_w[k], 20'h0);
      check("rst_overflow", ovf[k], 1'b0);
    end
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // 255 with the consumer stalled for 20 cycles after DONE.
    out_rdy[0] = 1'b0;
    send(0, 16'd255, 20'h00255, 1'b0, 1'b1);
    wait_valid(0);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1;
    out_rdy[0] = 1'b1;
    drain();

    // 0 then 99 back-to-back; accepts must be 10 cycles apart.
    send(0, 16'd0,  20'h00000, 1'b0, 1'b1);
    send(0, 16'd99, 20'h00099, 1'b0, 1'b1);
    drain();
    check("accept_spacing", last_acc[0] - prev_acc[0], 10);

    send(0, 16'd128, 20'h00128, 1'b0, 1'b1);
    drain();

    // Reset after 3 SHIFT cycles of 200; that conversion must vanish.
    send(0, 16'd200, 20'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_in_ready", in_rdy[0], 1'b1);
    check("midrst_out_valid", out_vld[0], 1'b0);
    check("midrst_bcd", bcd_w[0], 20'h0);
    check("midrst_overflow", ovf[0], 1'b0);
    begin
      exp_t e;
      e.bcd = 20'h00007;
      e.ovf = 1'b0;
      sb.push_back(e);
    end
    bin_s     = 16'd7;
    in_vld[0] = 1'b1;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    rel     = cyc;
    @(posedge clk);
    #1;
    in_vld[0] = 1'b0;
    drain();
    check("accept_after_reset", last_acc[0], rel + 1);

    // 16-bit, 5-digit instance.
    send(1, 16'd65535, 20'h65535, 1'b0, 1'b1);
    send(1, 16'd10000, 20'h10000, 1'b0, 1'b1);
    drain();

    // 8-bit, 2-digit instance: truncation and the boundary at 99/100.
    send(2, 16'd123, 20'h00023, 1'b1, 1'b1);
    send(2, 16'd99,  20'h00099, 1'b0, 1'b1);
    send(2, 16'd100, 20'h00000, 1'b1, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
